// File: rtl/test_signal_gen.sv
// I/Q test-pattern source (CONST / SQUARE / RAMP / PRBS) on a valid/ready stream.
// Patterns advance only on accepted samples; stopping always drains a pending sample.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | stopped, o_tvalid=0, o_tdata holds the last sample
// RUN   | streaming; each accepted sample loads the next one
// DRAIN | stop requested with a sample pending; hold it until accepted
module test_signal_gen #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PERIOD_W = 8,
    parameter logic [31:0] SEED     = 32'h0000_0001
) (
    input  logic                  radio_clk,
    input  logic                  radio_rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [PERIOD_W-1:0]   half_period,
    input  logic [WIDTH-1:0]      amplitude,
    output logic [2*WIDTH-1:0]    o_tdata,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic                  busy,
    output logic [31:0]           sample_cnt
);

    localparam int unsigned DW      = 2 * WIDTH;
    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    localparam logic [1:0] MODE_CONST  = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_RAMP   = 2'd2;
    localparam logic [1:0] MODE_PRBS   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [WIDTH-1:0]      amp_q, amp_d;
    logic [PERIOD_W-1:0]   half_q, half_d;
    logic [PERIOD_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic                  phase_high_q, phase_high_d;
    logic [WIDTH-1:0]      ramp_q, ramp_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [DW-1:0]         data_d;
    logic                  valid_d;
    logic [31:0]           cnt_d;

    logic                  xfer;
    logic                  load;
    logic [31:0]           cnt_inc;
    logic                  phase_wrap;
    logic [PERIOD_W-1:0]   adv_phase_cnt;
    logic                  adv_phase_high;
    logic [WIDTH-1:0]      adv_ramp;
    logic [31:0]           adv_lfsr;
    logic [DW-1:0]         sample_d;

    // Fibonacci LFSR, taps for x^32 + x^22 + x^2 + x + 1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    assign xfer    = o_tvalid & o_tready;
    assign busy    = (state_q != IDLE);
    assign cnt_inc = (sample_cnt == 32'hFFFF_FFFF) ? sample_cnt : sample_cnt + 32'd1;

    // Generator state after one accepted sample
    always_comb begin
        phase_wrap     = ((phase_cnt_q + 1'b1) == half_q);
        adv_phase_cnt  = phase_wrap ? '0 : phase_cnt_q + 1'b1;
        adv_phase_high = phase_wrap ? ~phase_high_q : phase_high_q;
        adv_ramp       = ramp_q + 1'b1;
        adv_lfsr       = lfsr_step(lfsr_q);
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        amp_d        = amp_q;
        half_d       = half_q;
        phase_cnt_d  = phase_cnt_q;
        phase_high_d = phase_high_q;
        ramp_d       = ramp_q;
        lfsr_d       = lfsr_q;
        valid_d      = o_tvalid;
        cnt_d        = sample_cnt;
        load         = 1'b0;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (enable) begin
                    state_d      = RUN;
                    mode_d       = mode;
                    amp_d        = amplitude;
                    half_d       = (half_period == '0) ? PERIOD_W'(1) : half_period;
                    phase_cnt_d  = '0;
                    phase_high_d = 1'b1;
                    ramp_d       = '0;
                    lfsr_d       = SEED_NZ;
                    cnt_d        = 32'd0;
                    valid_d      = 1'b1;
                    load         = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    if (xfer) begin
                        cnt_d   = cnt_inc;
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else if (!o_tvalid) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (xfer) begin
                    cnt_d        = cnt_inc;
                    phase_cnt_d  = adv_phase_cnt;
                    phase_high_d = adv_phase_high;
                    ramp_d       = adv_ramp;
                    lfsr_d       = adv_lfsr;
                    valid_d      = 1'b1;
                    load         = 1'b1;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    cnt_d   = cnt_inc;
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Sample built from the post-update generator state so it appears with o_tvalid
    always_comb begin
        sample_d = '0;
        unique case (mode_d)
            MODE_CONST:  sample_d = {amp_d, amp_d};
            MODE_SQUARE: sample_d = phase_high_d ? {amp_d, amp_d} : '0;
            MODE_RAMP:   sample_d = {ramp_d, ~ramp_d};
            MODE_PRBS:   sample_d = lfsr_d[DW-1:0];
            default:     sample_d = '0;
        endcase
        data_d = load ? sample_d : o_tdata;
    end

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            state_q      <= IDLE;
            mode_q       <= MODE_CONST;
            amp_q        <= '0;
            half_q       <= PERIOD_W'(1);
            phase_cnt_q  <= '0;
            phase_high_q <= 1'b1;
            ramp_q       <= '0;
            lfsr_q       <= SEED_NZ;
            o_tdata      <= '0;
            o_tvalid     <= 1'b0;
            sample_cnt   <= 32'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            amp_q        <= amp_d;
            half_q       <= half_d;
            phase_cnt_q  <= phase_cnt_d;
            phase_high_q <= phase_high_d;
            ramp_q       <= ramp_d;
            lfsr_q       <= lfsr_d;
            o_tdata      <= data_d;
            o_tvalid     <= valid_d;
            sample_cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_test_signal_gen.sv
// Directed bench for test_signal_gen: expected samples queued from a pattern model,
// compared every valid cycle and popped on each transfer.
module tb_test_signal_gen;

    localparam int WIDTH    = 16;
    localparam int PERIOD_W = 8;

    logic                radio_clk = 1'b0;
    logic                radio_rst_n;
    logic                enable;
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] half_period;
    logic [WIDTH-1:0]    amplitude;
    logic [2*WIDTH-1:0]  o_tdata;
    logic                o_tvalid;
    logic                o_tready;
    logic                busy;
    logic [31:0]         sample_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];

    int          m_mode;
    int          m_h;
    int          m_k;
    logic [15:0] m_amp;
    logic [31:0] m_lfsr;

    always #5 radio_clk = ~radio_clk;

    test_signal_gen #(
        .WIDTH    (WIDTH),
        .PERIOD_W (PERIOD_W),
        .SEED     (32'h0000_0001)
    ) dut (
        .radio_clk   (radio_clk),
        .radio_rst_n (radio_rst_n),
        .enable      (enable),
        .mode        (mode),
        .half_period (half_period),
        .amplitude   (amplitude),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .busy        (busy),
        .sample_cnt  (sample_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    function automatic logic [31:0] model_cur();
        logic [15:0] r;
        r = m_k[15:0];
        case (m_mode)
            0:       return {m_amp, m_amp};
            1:       return (((m_k / m_h) % 2) == 0) ? {m_amp, m_amp} : 32'd0;
            2:       return {r, ~r};
            default: return m_lfsr;
        endcase
    endfunction

    task automatic model_adv();
        m_k++;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: drive ready, compare the presented sample, pop on transfer
    task automatic tick(input logic rdy, output logic x);
        o_tready = rdy;
        x = o_tvalid & rdy;
        if (o_tvalid) begin
            chk("sb_pending", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                chk("data", o_tdata, sb[0]);
                if (x) void'(sb.pop_front());
            end
        end
        @(negedge radio_clk);
    endtask

    task automatic start(input logic [1:0] md, input logic [7:0] hp, input logic [15:0] amp);
        mode        = md;
        half_period = hp;
        amplitude   = amp;
        enable      = 1'b1;
        o_tready    = 1'b0;
        m_mode = int'(md);
        m_h    = (hp == 8'd0) ? 1 : int'(hp);
        m_amp  = amp;
        m_k    = 0;
        m_lfsr = 32'h0000_0001;
        @(negedge radio_clk);
        chk("start_valid", 32'(o_tvalid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cnt", sample_cnt, 32'd0);
        sb.push_back(model_cur());
    endtask

    task automatic run_xfers(input int n, input bit rand_rdy);
        int   got;
        int   cyc;
        logic x;
        logic r;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 4 * n + 20) begin
            r = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
            tick(r, x);
            cyc++;
            if (x) begin
                got++;
                model_adv();
                sb.push_back(model_cur());
            end
        end
        chk("xfer_budget", 32'(got), 32'(n));
        chk("sample_cnt", sample_cnt, 32'(m_k));
    endtask

    // Stop with `hold` stalled cycles (DRAIN), optionally raising enable during DRAIN
    task automatic stop(input int hold, input bit poke_enable);
        logic        x;
        logic [31:0] last;
        last   = (sb.size() > 0) ? sb[0] : 32'd0;
        enable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke_enable && i == hold - 1) enable = 1'b1;
            tick(1'b0, x);
            chk("drain_valid", 32'(o_tvalid), 32'd1);
            chk("drain_busy", 32'(busy), 32'd1);
        end
        tick(1'b1, x);
        enable = 1'b0;
        chk("stop_xfer", 32'(x), 32'd1);
        model_adv();
        chk("stop_valid", 32'(o_tvalid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_cnt", sample_cnt, 32'(m_k));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        o_tready = 1'b1;
        @(negedge radio_clk);
        chk("idle_valid", 32'(o_tvalid), 32'd0);
        chk("idle_hold", o_tdata, last);
        o_tready = 1'b0;
    endtask

    initial begin
        logic x;
        logic pat [5];
        radio_rst_n = 1'b0;
        enable      = 1'b0;
        mode        = 2'd0;
        half_period = '0;
        amplitude   = '0;
        o_tready    = 1'b0;
        @(negedge radio_clk);
        @(negedge radio_clk);
        chk("rst_valid", 32'(o_tvalid), 32'd0);
        chk("rst_data", o_tdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", sample_cnt, 32'd0);
        radio_rst_n = 1'b1;
        @(negedge radio_clk);
        chk("idle_no_enable", 32'(o_tvalid), 32'd0);

        // SQUARE, H=2 then H=max(0,1)=1
        start(2'd1, 8'd2, 16'hAAAA);
        chk("sq_first", o_tdata, 32'hAAAA_AAAA);
        run_xfers(9, 1'b0);
        stop(0, 1'b0);
        start(2'd1, 8'd0, 16'h1234);
        run_xfers(5, 1'b0);
        stop(0, 1'b0);

        // RAMP with ready 1,0,0,1,1 then run to the 16-bit wrap
        start(2'd2, 8'd0, 16'h0);
        chk("ramp_first", o_tdata, 32'h0000_FFFF);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            tick(pat[i], x);
            if (x) begin
                model_adv();
                sb.push_back(model_cur());
            end
        end
        chk("ramp_after_pat", o_tdata, 32'h0003_FFFC);
        chk("ramp_pat_cnt", sample_cnt, 32'd3);
        run_xfers(65536 - 3, 1'b0);
        chk("ramp_wrap", o_tdata, 32'h0000_FFFF);
        run_xfers(2, 1'b0);
        stop(0, 1'b0);

        // DRAIN: 3 stalled cycles, enable re-raised in DRAIN is ignored
        start(2'd0, 8'd0, 16'h5A5A);
        run_xfers(2, 1'b0);
        stop(3, 1'b1);

        // PRBS with random backpressure, then restart from seed
        start(2'd3, 8'd0, 16'h0);
        chk("prbs_first", o_tdata, 32'h0000_0001);
        run_xfers(1000, 1'b1);
        stop(2, 1'b0);
        start(2'd3, 8'd0, 16'h0);
        chk("prbs_restart", o_tdata, 32'h0000_0001);
        run_xfers(10, 1'b1);
        stop(0, 1'b0);

        // Config changes mid-run take effect only at the next start
        start(2'd0, 8'd5, 16'h1111);
        run_xfers(2, 1'b0);
        mode        = 2'd2;
        amplitude   = 16'h2222;
        half_period = 8'd3;
        run_xfers(3, 1'b0);
        chk("cfg_held", o_tdata, 32'h1111_1111);
        stop(0, 1'b0);
        start(2'd2, 8'd3, 16'h2222);
        chk("cfg_new", o_tdata, 32'h0000_FFFF);
        run_xfers(4, 1'b1);

        // Async reset mid-run
        chk("pre_rst_valid", 32'(o_tvalid), 32'd1);
        #2 radio_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_tvalid), 32'd0);
        chk("arst_data", o_tdata, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cnt", sample_cnt, 32'd0);
        sb.delete();
        enable   = 1'b0;
        o_tready = 1'b0;
        @(negedge radio_clk);
        radio_rst_n = 1'b1;
        @(negedge radio_clk);
        chk("post_rst_valid", 32'(o_tvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
